// File: rtl/msrv32_instr_issue_ctrl.sv
// Issue controller between fetch and the immediate generator / execute stage.
// Decodes the opcode on push into a two-entry buffer and presents the head entry with valid/ready.
module msrv32_instr_issue_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             ms_riscv32_mp_clk_in,
  input  logic             ms_riscv32_mp_rst_in,
  input  logic             instr_valid_in,
  input  logic [31:0]      instr_in,
  output logic             instr_ready_out,
  input  logic             flush_in,
  output logic             issue_valid_out,
  input  logic             issue_ready_in,
  output logic [24:0]      instr_out,
  output logic [2:0]       imm_type_out,
  output logic             illegal_instr_out,
  output logic [CNT_W-1:0] issue_count_out
);

  // state   | meaning
  // S_EMPTY | no buffered entries
  // S_ONE   | head entry valid
  // S_TWO   | head and tail valid, fetch stalled
  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t           state_q, state_d;
  logic [24:0]      head_instr_q, head_instr_d, tail_instr_q, tail_instr_d;
  logic [2:0]       head_type_q, head_type_d, tail_type_q, tail_type_d;
  logic             head_ill_q, head_ill_d, tail_ill_q, tail_ill_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic       push, pop;
  logic [2:0] new_type;
  logic       new_ill;

  // Opcodes with instr[1:0] != 2'b11 fall into the default arm as well.
  always_comb begin
    new_type = 3'b111;
    new_ill  = 1'b0;
    unique case (instr_in[6:0])
      7'b0110011:                         new_type = 3'b000;
      7'b0010011, 7'b0000011, 7'b1100111: new_type = 3'b001;
      7'b0100011:                         new_type = 3'b010;
      7'b1100011:                         new_type = 3'b011;
      7'b0110111, 7'b0010111:             new_type = 3'b100;
      7'b1101111:                         new_type = 3'b101;
      7'b1110011:                         new_type = 3'b110;
      default: begin
        new_type = 3'b111;
        new_ill  = 1'b1;
      end
    endcase
  end

  assign instr_ready_out   = (state_q != S_TWO);
  assign issue_valid_out   = (state_q != S_EMPTY);
  assign instr_out         = head_instr_q;
  assign imm_type_out      = head_type_q;
  assign illegal_instr_out = head_ill_q;
  assign issue_count_out   = count_q;

  assign push = instr_valid_in & instr_ready_out;
  assign pop  = issue_valid_out & issue_ready_in;

  always_comb begin
    state_d      = state_q;
    head_instr_d = head_instr_q;
    head_type_d  = head_type_q;
    head_ill_d   = head_ill_q;
    tail_instr_d = tail_instr_q;
    tail_type_d  = tail_type_q;
    tail_ill_d   = tail_ill_q;
    count_d      = count_q;

    if (flush_in) begin
      state_d = S_EMPTY;
    end else begin
      if (pop) count_d = count_q + CNT_W'(1);
      unique case (state_q)
        S_EMPTY: begin
          if (push) begin
            state_d      = S_ONE;
            head_instr_d = instr_in[31:7];
            head_type_d  = new_type;
            head_ill_d   = new_ill;
          end
        end
        S_ONE: begin
          if (push && pop) begin
            head_instr_d = instr_in[31:7];
            head_type_d  = new_type;
            head_ill_d   = new_ill;
          end else if (push) begin
            state_d      = S_TWO;
            tail_instr_d = instr_in[31:7];
            tail_type_d  = new_type;
            tail_ill_d   = new_ill;
          end else if (pop) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (pop) begin
            state_d      = S_ONE;
            head_instr_d = tail_instr_q;
            head_type_d  = tail_type_q;
            head_ill_d   = tail_ill_q;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_q      <= S_EMPTY;
      head_instr_q <= '0;
      head_type_q  <= '0;
      head_ill_q   <= 1'b0;
      tail_instr_q <= '0;
      tail_type_q  <= '0;
      tail_ill_q   <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      head_instr_q <= head_instr_d;
      head_type_q  <= head_type_d;
      head_ill_q   <= head_ill_d;
      tail_instr_q <= tail_instr_d;
      tail_type_q  <= tail_type_d;
      tail_ill_q   <= tail_ill_d;
      count_q      <= count_d;
    end
  end

endmodule
